// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and field widths for the game sequencer
package game_pkg;
    localparam int SCORE_W = 16;
    localparam int LIVES_W = 2;
    localparam int SPEED_W = 2;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } state_t;
endpackage

// File: rtl/bcd_inc4.sv
// bcd_inc4: combinational 4-digit BCD increment, saturating at 9999
module bcd_inc4
    import game_pkg::*;
(
    input  logic [SCORE_W-1:0] d,
    output logic [SCORE_W-1:0] q
);
    logic carry;
    always_comb begin
        q = d;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (d[4*i +: 4] == 4'd9) begin
                    q[4*i +: 4] = 4'd0;
                end else begin
                    q[4*i +: 4] = d[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (d == 16'h9999) q = d;
    end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame-based game sequencer driving ball hold/run, speed, score and lives
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 120,
    parameter int SPEED_STEP   = 5,
    parameter int SPEED_MAX    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 refresh_tick,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 hit,
    input  logic                 miss,
    output logic                 ball_hold,
    output logic                 ball_run,
    output logic [SPEED_W-1:0]   speed_lvl,
    output logic [SCORE_W-1:0]   score,
    output logic [LIVES_W-1:0]   lives,
    output logic                 game_over,
    output logic [2:0]           state_o
);
    localparam int FC_W = $clog2(SERVE_FRAMES);
    localparam int HC_W = $clog2(SPEED_STEP + 1);
    state_t state, state_n;
    logic start_q, pause_q, hit_q;
    logic start_ev, pause_ev, hit_ev;
    logic new_game, serve_done;
    logic [FC_W-1:0] frame_cnt;
    logic [HC_W-1:0] hit_cnt;
    logic [SCORE_W-1:0] score_inc;

    assign start_ev   = start & ~start_q;
    assign pause_ev   = pause & ~pause_q;
    assign hit_ev     = hit & ~hit_q;
    assign new_game   = (state == IDLE || state == OVER) && start_ev;
    assign serve_done = refresh_tick && frame_cnt == FC_W'(SERVE_FRAMES - 1);

    bcd_inc4 u_bcd (.d(score), .q(score_inc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // miss outranks a coincident pause event
    always_comb begin
        state_n = state;
        case (state)
            IDLE, OVER: state_n = start_ev ? SERVE : state;
            SERVE:      state_n = serve_done ? PLAY : SERVE;
            PLAY:       state_n = miss ? (lives == LIVES_W'(1) ? OVER : SERVE) : (pause_ev ? PAUSE : PLAY);
            PAUSE:      state_n = pause_ev ? PLAY : PAUSE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            hit_q     <= 1'b0;
            score     <= '0;
            lives     <= LIVES_W'(LIVES_INIT);
            speed_lvl <= '0;
            frame_cnt <= '0;
            hit_cnt   <= '0;
        end else begin
            start_q <= start;
            pause_q <= pause;
            hit_q   <= hit;
            if (new_game) begin
                score     <= '0;
                lives     <= LIVES_W'(LIVES_INIT);
                speed_lvl <= '0;
                frame_cnt <= '0;
                hit_cnt   <= '0;
            end
            if (state == SERVE && refresh_tick)
                frame_cnt <= serve_done ? '0 : frame_cnt + FC_W'(1);
            if (state == PLAY) begin
                if (hit_ev) begin
                    score <= score_inc;
                    if (hit_cnt == HC_W'(SPEED_STEP - 1)) begin
                        hit_cnt <= '0;
                        if (speed_lvl != SPEED_W'(SPEED_MAX))
                            speed_lvl <= speed_lvl + SPEED_W'(1);
                    end else begin
                        hit_cnt <= hit_cnt + HC_W'(1);
                    end
                end
                if (miss) begin
                    lives     <= lives - LIVES_W'(1);
                    frame_cnt <= '0;
                end
            end
        end
    end

    assign ball_hold = state inside {IDLE, SERVE, OVER};
    assign ball_run  = state == PLAY;
    assign game_over = state == OVER;
    assign state_o   = state;
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: scoreboard bench comparing game_ctrl against a rule-level game model
module tb_game_ctrl;
    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] sc;
        logic [1:0]  lv;
        logic [1:0]  sp;
        logic        hold;
        logic        run;
        logic        over;
    } snap_t;

    logic clk = 1'b0, reset = 1'b1;
    logic refresh_tick = 1'b0, start = 1'b0, pause = 1'b0, hit = 1'b0, miss = 1'b0;
    logic ball_hold, ball_run, game_over;
    logic [1:0] speed_lvl, lives;
    logic [15:0] score;
    logic [2:0] state_o;

    int compared = 0, mismatched = 0;
    snap_t exp_q[$];

    int m_phase, m_hits, m_lives, m_frames;
    bit prev_s, prev_p, prev_h;

    game_ctrl dut (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
        .pause(pause), .hit(hit), .miss(miss), .ball_hold(ball_hold),
        .ball_run(ball_run), .speed_lvl(speed_lvl), .score(score), .lives(lives),
        .game_over(game_over), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // phases: 0 idle, 1 serve, 2 play, 3 pause, 4 over; score and speed follow from hit count
    function automatic snap_t model_snap();
        snap_t s;
        s.st   = 3'(m_phase);
        s.sc   = to_bcd(m_hits > 9999 ? 9999 : m_hits);
        s.lv   = 2'(m_lives);
        s.sp   = 2'(m_hits / 5 > 3 ? 3 : m_hits / 5);
        s.hold = (m_phase == 0 || m_phase == 1 || m_phase == 4);
        s.run  = (m_phase == 2);
        s.over = (m_phase == 4);
        return s;
    endfunction

    function automatic snap_t dut_snap();
        return {state_o, score, lives, speed_lvl, ball_hold, ball_run, game_over};
    endfunction

    task automatic model_step();
        bit se, pe, he;
        if (reset) begin
            m_phase = 0; m_hits = 0; m_lives = 3; m_frames = 0;
            prev_s = 0; prev_p = 0; prev_h = 0;
            return;
        end
        se = start && !prev_s;
        pe = pause && !prev_p;
        he = hit && !prev_h;
        prev_s = start; prev_p = pause; prev_h = hit;
        case (m_phase)
            0, 4: if (se) begin m_phase = 1; m_hits = 0; m_lives = 3; m_frames = 0; end
            1: if (refresh_tick) begin
                m_frames++;
                if (m_frames == 120) begin m_phase = 2; m_frames = 0; end
            end
            2: begin
                if (he) m_hits++;
                if (miss) begin
                    m_lives--;
                    m_phase = (m_lives == 0) ? 4 : 1;
                    m_frames = 0;
                end else if (pe) m_phase = 3;
            end
            3: if (pe) m_phase = 2;
            default: m_phase = 0;
        endcase
    endtask

    task automatic step();
        snap_t e;
        model_step();
        e = model_snap();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic hit_pulse(int len);
        hit = 1'b1; steps(len);
        hit = 1'b0; steps(1 + $urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    task automatic pulse_pause();
        pause = 1'b1; step(); pause = 1'b0; step();
    endtask

    task automatic serve();
        int n = 0;
        while (n < 120) begin
            refresh_tick = ($urandom_range(0, 3) != 0);
            if (refresh_tick) n++;
            step();
        end
        refresh_tick = 1'b0;
        step();
    endtask

    task automatic do_miss();
        miss = 1'b1; step(); miss = 1'b0; step();
    endtask

    always @(negedge clk) begin
        snap_t a, e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = dut_snap();
            compared++;
            if (a !== e) begin
                mismatched++;
                $display("FAIL snapshot t=%0t: got st=%0d sc=%h lv=%0d sp=%0d hold=%b run=%b over=%b, expected st=%0d sc=%h lv=%0d sp=%0d hold=%b run=%b over=%b",
                         $time, a.st, a.sc, a.lv, a.sp, a.hold, a.run, a.over,
                         e.st, e.sc, e.lv, e.sp, e.hold, e.run, e.over);
            end
        end
    end

    initial begin
        snap_t r, a;
        steps(3);
        reset = 1'b0;
        steps(2);
        pulse_start();
        serve();
        for (int i = 0; i < 5; i++) hit_pulse(i == 2 ? 10 : 1);
        for (int i = 0; i < 20; i++) hit_pulse(1 + $urandom_range(0, 3));
        while (m_hits < 10003) hit_pulse(1);
        do_miss(); serve();
        do_miss(); serve();
        do_miss();
        steps(3);
        pulse_start();
        serve();
        for (int i = 0; i < 7; i++) hit_pulse(1);
        pulse_pause();
        for (int i = 0; i < 3; i++) hit_pulse(2);
        miss = 1'b1; step(); miss = 1'b0; step();
        pulse_pause();
        hit_pulse(1);
        pause = 1'b1; miss = 1'b1; step();
        pause = 1'b0; miss = 1'b0; step();
        serve();
        do_miss(); serve();
        hit_pulse(1);
        hit = 1'b1; miss = 1'b1; step();
        hit = 1'b0; miss = 1'b0; steps(3);
        pulse_start();
        refresh_tick = 1'b1; steps(50); refresh_tick = 1'b0;
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        r = {3'd0, 16'h0000, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0};
        a = dut_snap();
        compared++;
        if (a !== r) begin
            mismatched++;
            $display("FAIL async_reset: got %h, expected %h", a, r);
        end
        steps(2);
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 19) == 0);
            pause        = ($urandom_range(0, 9) == 0);
            hit          = ($urandom_range(0, 3) == 0);
            miss         = ($urandom_range(0, 29) == 0);
            refresh_tick = ($urandom_range(0, 1) == 0);
            step();
        end
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
